// File: rtl/dot_mac_ctrl.sv
// Dot-product sequencer for an external 8x8 shift-add multiplier.
// Issues one operand pair per start pulse, accumulates LEN products and hands the sum downstream.
module dot_mac_ctrl #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = 24
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  output logic             mul_start,
  input  logic [16:0]      mul_o,
  input  logic             mul_fin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  localparam logic [7:0] LEN_C     = 8'(LEN);
  localparam logic [3:0] WAIT_LAST = 4'd15;

  state_t         state, state_nxt;
  logic [7:0]     cnt;
  logic [3:0]     wcnt;
  logic [ACC_W:0] sum;
  logic           last_pair;

  always_comb begin
    sum       = {1'b0, acc_out} + {{(ACC_W-16){1'b0}}, mul_o};
    last_pair = (cnt + 8'd1) == LEN_C;
    state_nxt = state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = START;
      end
      START: begin
        mul_start = 1'b1;
        state_nxt = WAIT;
      end
      // fin is checked before the timeout so a fin on the last allowed cycle still counts
      WAIT: begin
        if (mul_fin)                state_nxt = last_pair ? OUT : IDLE;
        else if (wcnt == WAIT_LAST) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mul_a   <= '0;
      mul_b   <= '0;
      acc_out <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      wcnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_a <= in_a;
            mul_b <= in_b;
          end
        end
        START: wcnt <= '0;
        WAIT: begin
          wcnt <= wcnt + 4'd1;
          if (mul_fin) begin
            acc_out <= sum[ACC_W-1:0];
            ovf     <= ovf | sum[ACC_W];
            cnt     <= cnt + 8'd1;
          end else if (wcnt == WAIT_LAST) begin
            err <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            acc_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_mac_ctrl.sv
// Scoreboard bench for dot_mac_ctrl: two instances (LEN=4/ACC_W=24 and LEN=3/ACC_W=17)
// driven by a behavioural shift-add multiplier model.
`timescale 1ns/1ps
module tb_dot_mac_ctrl;

  localparam int unsigned LEN0 = 4, ACC_W0 = 24;
  localparam int unsigned LEN1 = 3, ACC_W1 = 17;

  typedef struct {
    logic [31:0] acc;
    logic        ovf;
    logic        err;
  } exp_t;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic              rst_n;
  logic              in_valid  [2];
  logic              in_ready  [2];
  logic [7:0]        in_a      [2];
  logic [7:0]        in_b      [2];
  logic [7:0]        mul_a     [2];
  logic [7:0]        mul_b     [2];
  logic              mul_start [2];
  logic [16:0]       mul_o     [2];
  logic              mul_fin   [2];
  logic              out_valid [2];
  logic              out_ready [2];
  logic              ovf       [2];
  logic              err       [2];
  logic              busy      [2];
  logic [ACC_W0-1:0] acc0;
  logic [ACC_W1-1:0] acc1;

  logic fin_en [2];
  logic stray_en;
  int   rdy_mode;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   pa [8];
  int   pb [8];

  dot_mac_ctrl #(.LEN(LEN0), .ACC_W(ACC_W0)) u_dut0 (
    .ck(ck), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]),
    .mul_start(mul_start[0]), .mul_o(mul_o[0]), .mul_fin(mul_fin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .acc_out(acc0),
    .ovf(ovf[0]), .err(err[0]), .busy(busy[0])
  );

  dot_mac_ctrl #(.LEN(LEN1), .ACC_W(ACC_W1)) u_dut1 (
    .ck(ck), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]),
    .mul_start(mul_start[1]), .mul_o(mul_o[1]), .mul_fin(mul_fin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .acc_out(acc1),
    .ovf(ovf[1]), .err(err[1]), .busy(busy[1])
  );

  function automatic logic [31:0] acc_of(input int i);
    return (i == 0) ? 32'(acc0) : 32'(acc1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  // Reference: plain sum of products, wrapped at 2^ACC_W; ovf means the true sum reached 2^ACC_W.
  function automatic exp_t exp_of(input int i, input int n);
    longint unsigned tot = 0;
    longint unsigned m;
    exp_t e;
    m = 64'd1 << ((i == 0) ? ACC_W0 : ACC_W1);
    for (int j = 0; j < n; j++) tot += 64'(pa[j]) * 64'(pb[j]);
    e.acc = 32'(tot % m);
    e.ovf = (tot >= m);
    e.err = 1'b0;
    return e;
  endfunction

  task automatic push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic pop_cmp(input int i);
    exp_t e;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_result[%0d]: got acc_out=%0d, expected no result", i, acc_of(i));
      return;
    end
    if (i == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("acc_out[%0d]", i), acc_of(i), e.acc);
    chk($sformatf("ovf[%0d]", i), 32'(ovf[i]), 32'(e.ovf));
    chk($sformatf("err[%0d]", i), 32'(err[i]), 32'(e.err));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic send(input int i, input logic [7:0] a, input logic [7:0] b, input bit hold);
    int n = 0;
    @(negedge ck);
    in_a[i] = a;
    in_b[i] = b;
    in_valid[i] = 1'b1;
    while (!in_ready[i]) begin
      n++;
      if (n > 300) begin
        bound_fail("send_accept");
        in_valid[i] = 1'b0;
        return;
      end
      @(negedge ck);
    end
    @(posedge ck);
    #1;
    if (!hold) in_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    @(negedge ck);
    while (!in_ready[i]) begin
      n++;
      if (n > 300) begin
        bound_fail("wait_idle");
        return;
      end
      @(negedge ck);
    end
  endtask

  task automatic wait_out(input int i, output int c);
    c = 0;
    do begin
      @(negedge ck);
      c++;
    end while (!out_valid[i] && c < 300);
    if (!out_valid[i]) bound_fail("wait_out_valid");
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q0.size() != 0 || q1.size() != 0) begin
      @(negedge ck);
      n++;
      if (n > 3000) begin
        bound_fail("drain_scoreboard");
        return;
      end
    end
  endtask

  task automatic issue(input int i, input int n, input bit gaps);
    push(i, exp_of(i, n));
    for (int j = 0; j < n; j++) begin
      send(i, 8'(pa[j]), 8'(pb[j]), 1'b0);
      if (gaps && $urandom_range(0, 2) == 0) wait_cyc($urandom_range(1, 3));
    end
  endtask

  // Behavioural multiplier: loads on a sampled start, raises fin for one cycle in the
  // 8th cycle after loading; O is garbage whenever fin is low.
  initial begin
    int   k    [2];
    logic st_s [2];
    logic [16:0] prod   [2];
    logic [16:0] prod_n [2];
    for (int i = 0; i < 2; i++) begin
      k[i] = 0;
      mul_fin[i] = 1'b0;
      mul_o[i] = '0;
      prod[i] = '0;
      prod_n[i] = '0;
    end
    forever begin
      @(negedge ck);
      for (int i = 0; i < 2; i++) begin
        st_s[i] = mul_start[i];
        if (mul_start[i]) prod_n[i] = 17'(mul_a[i]) * 17'(mul_b[i]);
      end
      @(posedge ck);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (st_s[i] === 1'b1) begin
          k[i] = 1;
          prod[i] = prod_n[i];
        end else if (k[i] != 0) begin
          k[i] = (k[i] == 8) ? 0 : k[i] + 1;
        end
        if (k[i] == 8 && fin_en[i]) begin
          mul_fin[i] = 1'b1;
          mul_o[i] = prod[i];
        end else begin
          mul_o[i] = 17'($urandom);
          mul_fin[i] = (stray_en && (in_ready[i] || out_valid[i])) ? 1'($urandom) : 1'b0;
        end
      end
    end
  end

  // out_ready driver: 0 = stall, 1 = always ready, 2 = random
  initial begin
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    forever begin
      @(posedge ck);
      #1;
      for (int i = 0; i < 2; i++)
        out_ready[i] = (rdy_mode == 2) ? 1'($urandom) : (rdy_mode == 1);
    end
  end

  // Monitor: pops the scoreboard on every accepted result, checks start is a single pulse.
  initial begin
    logic prev_st [2];
    prev_st[0] = 1'b0;
    prev_st[1] = 1'b0;
    forever begin
      @(negedge ck);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (mul_start[i]) chk($sformatf("start_back_to_back[%0d]", i), 32'(prev_st[i]), 0);
          prev_st[i] = mul_start[i];
          if (out_valid[i] && out_ready[i]) pop_cmp(i);
        end
      end else begin
        prev_st[0] = 1'b0;
        prev_st[1] = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1;
    int   c;
    int   st_cnt;
    int   inst;
    int   n;
    logic [7:0] x, y;

    rst_n = 1'b0;
    rdy_mode = 1;
    stray_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_a[i] = '0;
      in_b[i] = '0;
      fin_en[i] = 1'b1;
    end

    // Reset values
    wait_cyc(3);
    chk("rst_mul_a", 32'(mul_a[0]), 0);
    chk("rst_mul_b", 32'(mul_b[0]), 0);
    chk("rst_mul_start", 32'(mul_start[0]), 0);
    chk("rst_acc_out", acc_of(0), 0);
    chk("rst_out_valid", 32'(out_valid[0]), 0);
    chk("rst_ovf", 32'(ovf[0]), 0);
    chk("rst_err", 32'(err[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    rst_n = 1'b1;
    @(negedge ck);
    chk("rst_in_ready", 32'(in_ready[0]), 1);

    // Known dot product: 15 + 200 + 65025 + 0
    pa[0] = 3;   pb[0] = 5;
    pa[1] = 10;  pb[1] = 20;
    pa[2] = 255; pb[2] = 255;
    pa[3] = 0;   pb[3] = 7;
    issue(0, LEN0, 1'b0);
    wait_drain();

    // Single-pair timing with in_valid held high
    pa[0] = 12; pb[0] = 11;
    for (int j = 1; j < 4; j++) begin
      pa[j] = $urandom_range(0, 255);
      pb[j] = $urandom_range(0, 255);
    end
    push(0, exp_of(0, 4));
    @(negedge ck);
    in_a[0] = 8'd12;
    in_b[0] = 8'd11;
    in_valid[0] = 1'b1;
    chk("accept_ready", 32'(in_ready[0]), 1);
    @(posedge ck);
    #1;
    in_a[0] = 8'(pa[1]);
    in_b[0] = 8'(pb[1]);
    st_cnt = 0;
    for (int cc = 1; cc <= 10; cc++) begin
      @(negedge ck);
      if (mul_start[0]) st_cnt++;
      if (cc == 1) begin
        chk("start_after_accept", 32'(mul_start[0]), 1);
        chk("mul_a_at_start", 32'(mul_a[0]), 12);
        chk("mul_b_at_start", 32'(mul_b[0]), 11);
      end
      if (cc == 9) chk("mul_a_stable", 32'(mul_a[0]), 12);
      chk($sformatf("in_ready_cycle%0d", cc), 32'(in_ready[0]), (cc == 10) ? 1 : 0);
    end
    chk("start_pulse_count", 32'(st_cnt), 1);
    @(posedge ck);
    #1;
    in_valid[0] = 1'b0;
    send(0, 8'(pa[2]), 8'(pb[2]), 1'b0);
    send(0, 8'(pa[3]), 8'(pb[3]), 1'b0);
    wait_drain();

    // Result backpressure with the next pair already waiting
    rdy_mode = 0;
    for (int j = 0; j < 4; j++) begin
      pa[j] = $urandom_range(0, 255);
      pb[j] = $urandom_range(0, 255);
    end
    e1 = exp_of(0, 4);
    push(0, e1);
    for (int j = 0; j < 4; j++) send(0, 8'(pa[j]), 8'(pb[j]), j == 3);
    x = 8'($urandom);
    y = 8'($urandom);
    in_a[0] = x;
    in_b[0] = y;
    pa[0] = x; pb[0] = y;
    for (int j = 1; j < 4; j++) begin
      pa[j] = $urandom_range(0, 255);
      pb[j] = $urandom_range(0, 255);
    end
    push(0, exp_of(0, 4));
    wait_out(0, c);
    for (int cc = 0; cc < 5; cc++) begin
      @(negedge ck);
      chk("bp_out_valid", 32'(out_valid[0]), 1);
      chk("bp_acc_out", acc_of(0), e1.acc);
      chk("bp_ovf", 32'(ovf[0]), 32'(e1.ovf));
      chk("bp_err", 32'(err[0]), 0);
      chk("bp_in_ready", 32'(in_ready[0]), 0);
    end
    rdy_mode = 1;
    for (int j = 0; j < 4; j++) send(0, 8'(pa[j]), 8'(pb[j]), 1'b0);
    wait_drain();

    // Multiplier timeout on the third pair, stray fin in OUT and IDLE
    rdy_mode = 0;
    for (int j = 0; j < 3; j++) begin
      pa[j] = $urandom_range(0, 255);
      pb[j] = $urandom_range(0, 255);
    end
    e1 = exp_of(0, 2);
    e1.err = 1'b1;
    push(0, e1);
    send(0, 8'(pa[0]), 8'(pb[0]), 1'b0);
    send(0, 8'(pa[1]), 8'(pb[1]), 1'b0);
    wait_idle(0);
    fin_en[0] = 1'b0;
    send(0, 8'(pa[2]), 8'(pb[2]), 1'b0);
    wait_out(0, c);
    chk("timeout_latency", 32'(c), 18);
    fin_en[0] = 1'b1;
    stray_en = 1'b1;
    for (int cc = 0; cc < 6; cc++) begin
      @(negedge ck);
      chk("to_out_valid", 32'(out_valid[0]), 1);
      chk("to_err", 32'(err[0]), 1);
      chk("to_acc_hold", acc_of(0), e1.acc);
    end
    rdy_mode = 1;
    wait_cyc(8);
    chk("stray_idle_acc", acc_of(0), 0);
    chk("stray_idle_busy", 32'(busy[0]), 0);
    stray_en = 1'b0;
    wait_drain();

    // Reset in the 4th WAIT cycle of the second pair
    send(0, 8'd9, 8'd9, 1'b0);
    send(0, 8'd4, 8'd4, 1'b0);
    wait_cyc(5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy[0]), 0);
    chk("mid_rst_acc_out", acc_of(0), 0);
    chk("mid_rst_mul_a", 32'(mul_a[0]), 0);
    chk("mid_rst_out_valid", 32'(out_valid[0]), 0);
    chk("mid_rst_err", 32'(err[0]), 0);
    @(negedge ck);
    rst_n = 1'b1;
    wait_cyc(8);
    for (int j = 0; j < 4; j++) begin
      pa[j] = 2;
      pb[j] = 2;
    end
    issue(0, LEN0, 1'b0);
    wait_drain();

    // Narrow accumulator: 3 * 65025 wraps at 2^17
    for (int j = 0; j < 3; j++) begin
      pa[j] = 255;
      pb[j] = 255;
    end
    issue(1, LEN1, 1'b0);
    pa[0] = 1; pb[0] = 1;
    pa[1] = 2; pb[1] = 3;
    pa[2] = 4; pb[2] = 5;
    issue(1, LEN1, 1'b0);
    wait_drain();

    // Randomized traffic on both instances
    rdy_mode = 2;
    for (int t = 0; t < 24; t++) begin
      inst = (t % 4 == 3) ? 1 : 0;
      n = (inst == 0) ? LEN0 : LEN1;
      for (int j = 0; j < n; j++) begin
        pa[j] = (inst == 1) ? $urandom_range(120, 255) : $urandom_range(0, 255);
        pb[j] = (inst == 1) ? $urandom_range(120, 255) : $urandom_range(0, 255);
      end
      issue(inst, n, 1'b1);
    end
    wait_drain();
    rdy_mode = 1;
    wait_cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
